// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ producers onto one FIFO write port.
// Each accepted word is confirmed through the FIFO's registered ack; an overflow parks the word and retries it.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          retry_cnt,
  output logic                          proto_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, HOLD} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [FIFO_WIDTH-1:0] r_data;
  logic                  r_wr_en;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_retry;
  logic                  r_perr;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_any;
  logic [PTR_W-1:0]      w_win;
  logic [FIFO_WIDTH-1:0] w_win_data;
  logic [NUM_REQ-1:0]    w_owner_oh;
  int                    w_idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The requester whose gnt is pulsing is masked so a held req cannot win twice back to back.
  always_comb begin
    w_elig = req & ~r_gnt;
    w_any  = |w_elig;
    w_win  = r_ptr;
    w_idx  = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (w_elig[w_idx]) w_win = PTR_W'(w_idx);
    end
    w_win_data = req_data[int'(w_win)*FIFO_WIDTH +: FIFO_WIDTH];
    w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_retry <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_gnt   <= '0;
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any && !fifo_full) begin
            r_owner <= w_win;
            r_data  <= w_win_data;
            r_wr_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= CHECK;
        end
        CHECK: begin
          // Ack wins over overflow; seeing both at once is still flagged as a protocol error.
          if (fifo_wr_ack) begin
            r_gnt   <= w_owner_oh;
            r_ptr   <= wrap_inc(r_owner);
            r_busy  <= 1'b0;
            r_state <= IDLE;
            if (fifo_overflow) r_perr <= 1'b1;
          end else if (fifo_overflow) begin
            r_retry <= sat_inc(r_retry);
            r_state <= HOLD;
          end else begin
            r_perr  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (!fifo_full) begin
            r_wr_en <= 1'b1;
            r_state <= ISSUE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign busy         = r_busy;
  assign retry_cnt    = r_retry;
  assign proto_err    = r_perr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small FIFO write-side responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int FW = 16;
  localparam int CW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*FW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             fifo_wr_en;
  logic [FW-1:0]    fifo_data_in;
  logic             fifo_full;
  logic             fifo_wr_ack;
  logic             fifo_overflow;
  logic             busy;
  logic [CW-1:0]    retry_cnt;
  logic             proto_err;

  logic             m_ovf;
  logic             m_mute;
  logic [FW-1:0]    wr_log [0:63];
  int               wr_n;
  int               cyc = 0;
  int               n_total = 0;
  int               n_bad = 0;
  logic [FW-1:0]    dat [0:NR-1];
  int               t_gnt [0:5];

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_wr_ack  (fifo_wr_ack),
    .fifo_overflow(fifo_overflow),
    .busy         (busy),
    .retry_cnt    (retry_cnt),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO write side: ack or overflow one cycle after wr_en, accepted words logged in order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ack   <= 1'b0;
      fifo_overflow <= 1'b0;
      wr_n          <= 0;
    end else begin
      fifo_wr_ack   <= fifo_wr_en && !m_mute && !m_ovf;
      fifo_overflow <= fifo_wr_en && !m_mute && m_ovf;
      if (fifo_wr_en && !m_mute && !m_ovf) begin
        wr_log[wr_n % 64] <= fifo_data_in;
        wr_n <= wr_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input int exp_idx);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 40);
    check(tag, 32'(gnt), 32'(1) << exp_idx);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    m_ovf     = 1'b0;
    m_mute    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dat[0] = 16'hA5A5;
    dat[1] = 16'h5A5A;
    dat[2] = 16'h0F0F;
    dat[3] = 16'hC3C3;
    req_data = {dat[3], dat[2], dat[1], dat[0]};

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_perr", 32'(proto_err), 0);

    // Single requester, latency and one-cycle pulses
    req = 4'b0001;
    @(negedge clk);
    check("t1_wr_en", 32'(fifo_wr_en), 1);
    check("t1_data", 32'(fifo_data_in), 32'h0000A5A5);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_wr_en_off", 32'(fifo_wr_en), 0);
    check("t1_gnt_early", 32'(gnt), 0);
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_busy_idle", 32'(busy), 0);
    req = '0;
    @(negedge clk);
    check("t1_gnt_pulse", 32'(gnt), 0);
    check("t1_retry", 32'(retry_cnt), 0);
    check("t1_log", 32'(wr_log[0]), 32'h0000A5A5);

    // All requesting: order 0,1,2,3,0,1 at 3-cycle spacing
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_gnt($sformatf("t2_gnt%0d", i), i % 4);
      t_gnt[i] = cyc;
    end
    req = '0;
    for (int i = 1; i < 6; i++) check($sformatf("t2_space%0d", i), 32'(t_gnt[i] - t_gnt[i-1]), 3);
    check("t2_count", 32'(wr_n), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_word%0d", i), 32'(wr_log[i]), 32'(dat[i % 4]));

    // Wrap-around: pointer at 3 after granting 2, then 3 and 0
    req = 4'b0100;
    wait_gnt("t3_gnt2", 2);
    req = 4'b1001;
    wait_gnt("t3_gnt3", 3);
    req = 4'b0001;
    wait_gnt("t3_gnt0", 0);
    req = '0;
    check("t3_word2", 32'(wr_log[6]), 32'(dat[2]));
    check("t3_word3", 32'(wr_log[7]), 32'(dat[3]));
    check("t3_word0", 32'(wr_log[8]), 32'(dat[0]));

    // Full blocks arbitration; overflow parks the word in HOLD, then it is rewritten
    do_reset();
    fifo_full = 1'b1;
    req = 4'b0010;
    repeat (3) @(negedge clk);
    check("t4_full_wr_en", 32'(fifo_wr_en), 0);
    check("t4_full_busy", 32'(busy), 0);
    fifo_full = 1'b0;
    m_ovf = 1'b1;
    @(negedge clk);
    check("t4_wr_en", 32'(fifo_wr_en), 1);
    fifo_full = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_retry", 32'(retry_cnt), 1);
    check("t4_busy_hold", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_gnt", 32'(gnt), 0);
      check("t4_hold_wr_en", 32'(fifo_wr_en), 0);
      @(negedge clk);
    end
    m_ovf = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
    check("t4_rewr_en", 32'(fifo_wr_en), 1);
    check("t4_rewr_data", 32'(fifo_data_in), 32'(dat[1]));
    wait_gnt("t4_gnt", 1);
    req = '0;
    check("t4_retry_keep", 32'(retry_cnt), 1);
    check("t4_log", 32'(wr_log[0]), 32'(dat[1]));

    // Reset while in CHECK: pointer returns to 0, no grant for the abandoned word
    do_reset();
    req = 4'b0010;
    wait_gnt("t5_pre", 1);
    req = 4'b0001;
    repeat (2) @(negedge clk);
    check("t5_in_check", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_gnt", 32'(gnt), 0);
    check("t5_rst_data", 32'(fifo_data_in), 0);
    @(negedge clk);
    check("t5_rst_gnt2", 32'(gnt), 0);
    req = 4'b0101;
    rst_n = 1'b1;
    wait_gnt("t5_ptr0", 0);
    req = 4'b0100;
    wait_gnt("t5_gnt2", 2);

    // No ack and no overflow: sticky protocol error
    m_mute = 1'b1;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    check("t6_perr", 32'(proto_err), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_gnt", 32'(gnt), 0);
    req = '0;
    m_mute = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_perr_sticky", 32'(proto_err), 1);
    req = 4'b0010;
    wait_gnt("t6_gnt_after", 1);
    req = '0;
    check("t6_perr_keep", 32'(proto_err), 1);
    do_reset();
    check("t6_perr_clr", 32'(proto_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
